pre_entry_n: RTL and testbench
==============================

# pre_entry_n

Parametrised front-panel entry controller for the washing-machine pre-stage. The user dials a BCD amount with per-digit increment switches and tops up a running binary balance, then picks a wash mode and requests a start. A start is granted only if the balance covers the mode price; the price is deducted when the wash controller acknowledges. The block sits between the existing `button` debouncers / `scan4` display driver and the wash controller.

## Interface
Parameters:
- DIGITS, 3, number of BCD entry digits (1..4)
- TICK, 66000000, clock cycles per auto-increment step
- MODES, 4, number of selectable wash modes (2..16)
- PRICE_STEP, 5, price of mode m is (m+1)*PRICE_STEP
- BAL_W, 14, balance width; BAL_MAX = 10^DIGITS-1 must fit

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- on  in  1  enable; low freezes all state, counters and pulses
- inc  in  DIGITS  increment switches, bit 0 = units digit
- sign  in  1  sign switch
- mid_pulse  in  1  confirm, one-cycle pulse from `button`
- right_pulse  in  1  mode step, one-cycle pulse from `button`
- start_ack  in  1  wash controller accepts start
- digits  out  4*DIGITS  BCD entry digits, units in [3:0]
- neg  out  1  entered sign is negative (display code 10 upstream)
- mode  out  4  selected mode, 0..MODES-1
- bal  out  BAL_W  binary balance
- st_light  out  3  state lamps
- start_req  out  1  start request, held until ack
- price_err  out  1  one-cycle pulse: insufficient balance

## Operation
- States: ENTRY, MODE, READY. st_light = 001 / 011 / 111.
- ENTRY:
  - Tick counter counts 0..TICK-1.
  - On the terminal count, each digit with inc[i]=1 increments mod 10 (9 -> 0), and sign=1 toggles neg.
  - On mid_pulse with inc==0, sign==0 and neg==0: go to MODE, mode<=0, bal <= min(bal + value(digits), BAL_MAX), digits cleared.
  - On mid_pulse otherwise: digits and neg cleared, stay in ENTRY, bal unchanged.
- MODE:
  - right_pulse: mode <= (mode==MODES-1) ? 0 : mode+1.
  - mid_pulse with bal >= price(mode): go to READY, start_req <= 1.
  - mid_pulse with bal < price(mode): price_err pulses for one cycle, stay in MODE.
- READY:
  - start_req is held high. right_pulse and mid_pulse are ignored.
  - On start_ack: bal <= bal - price(mode), start_req <= 0, go to ENTRY, tick counter <= 0.
- value(digits) is the BCD-to-binary sum of digit[i]*10^i, computed combinationally.
- price(mode) is computed at BAL_W width.

## Timing
- All outputs are registered. Effects are visible on the clock edge following the triggering input.
- Reset values: state ENTRY, digits 0, neg 0, mode 0, bal 0, start_req 0, price_err 0, tick counter 0, st_light 001.
- Reset is asynchronous: asserting rst mid-operation (including in READY) clears everything immediately, with no deduction.
- on=0:
  - Nothing changes, including the tick counter and start_req.
  - start_ack, mid_pulse and right_pulse arriving while on=0 are lost.
- Tick counter is cleared on every entry into ENTRY. It does not run in MODE or READY.
- Simultaneous events:
  - mid_pulse on the same cycle as the ENTRY terminal tick: mid_pulse wins and that tick's digit updates are discarded. The counter still wraps to 0.
  - mid_pulse with right_pulse in MODE: mid wins, price check uses the current (pre-step) mode, and the step is dropped.
- bal saturates at BAL_MAX when topping up. Deduction cannot underflow because it is pre-checked.
- First increment occurs TICK cycles after entering ENTRY with a switch held.

## Test plan
Simulate with TICK=4, DIGITS=3, MODES=4, PRICE_STEP=5.
- Reset, set inc=3'b011 for 8 cycles, then clear -> digits=0x022 after 2 ticks. mid_pulse -> state MODE, bal=22, st_light=011, digits=0.
- In MODE with bal=22, right_pulse x3 -> mode=3, price 20. mid_pulse -> start_req=1, st_light=111. start_ack -> bal=2, state ENTRY, start_req=0.
- With bal=2 from the previous scenario, enter 005 -> bal=7. right_pulse x2 to mode 2 (price 15). mid_pulse -> price_err for 1 cycle, stay in MODE. right_pulse x2 wraps to mode 0 (price 5). mid_pulse -> READY.
- sign held for one tick -> neg=1. mid_pulse -> digits and neg cleared, still ENTRY, bal unchanged. mid_pulse while inc[0]=1 -> same clear.
- Saturation: bal=990, enter 999 -> bal=999. mid_pulse coincident with terminal tick while inc=3'b001 -> digits not incremented.
- Freeze and reset: on=0 for 20 cycles with inc set -> no change. rst asserted in READY -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pre_entry_n_if.sv
// Front-panel bundle between the entry controller and its
// neighbours: debounced buttons/switches in, display and wash status out.
interface pre_entry_n_if #(
  parameter int DIGITS = 3,
  parameter int BAL_W  = 14
);
  logic                  on;
  logic [DIGITS-1:0]     inc;
  logic                  sign;
  logic                  mid_pulse;
  logic                  right_pulse;
  logic                  start_ack;
  logic [4*DIGITS-1:0]   digits;
  logic                  neg;
  logic [3:0]            mode;
  logic [BAL_W-1:0]      bal;
  logic [2:0]            st_light;
  logic                  start_req;
  logic                  price_err;

  modport master (
    output on, inc, sign, mid_pulse,
    output right_pulse, start_ack,
    input  digits, neg, mode, bal,
    input  st_light, start_req, price_err
  );

  modport slave (
    input  on, inc, sign, mid_pulse,
    input  right_pulse, start_ack,
    output digits, neg, mode, bal,
    output st_light, start_req, price_err
  );
endinterface

// File: rtl/pre_entry_n.sv
// Washing-machine pre-stage entry controller: BCD top-up entry,
// mode selection with price check, start handshake with deduction.
module pre_entry_n #(
  parameter int DIGITS     = 3,
  parameter int TICK       = 66000000,
  parameter int MODES      = 4,
  parameter int PRICE_STEP = 5,
  parameter int BAL_W      = 14
) (
  input logic         clk,
  input logic         rst,
  pre_entry_n_if.slave bus
);

  localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [BAL_W-1:0] BAL_MAX =
    BAL_W'(10 ** DIGITS - 1);
  localparam logic [3:0] MODE_LAST = 4'(MODES - 1);

  typedef enum logic [1:0] {
    ENTRY,
    MODE,
    READY
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [DIGITS-1:0][3:0]  dig_q, dig_d;
  logic                    neg_q, neg_d;
  logic [3:0]              mode_q, mode_d;
  logic [BAL_W-1:0]        bal_q, bal_d;
  logic                    req_q, req_d;
  logic                    perr_q, perr_d;

  logic [BAL_W:0]   val;
  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] topped;
  logic [BAL_W-1:0] price;
  logic             term;
  logic             clean;

  // Horner evaluation of the BCD entry, one guard bit for the top-up sum
  always_comb begin
    val = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      val = val * (BAL_W + 1)'(10) + (BAL_W + 1)'(dig_q[i]);
    end
  end

  assign sum    = {1'b0, bal_q} + val;
  assign topped = (sum > {1'b0, BAL_MAX}) ?
                  BAL_MAX : sum[BAL_W-1:0];
  assign price  = (BAL_W'(mode_q) + BAL_W'(1)) *
                  BAL_W'(PRICE_STEP);
  assign term   = (tick_q == TICK_LAST);
  assign clean  = (bus.inc == '0) && !bus.sign && !neg_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    mode_d  = mode_q;
    bal_d   = bal_q;
    req_d   = req_q;
    perr_d  = perr_q;
    if (bus.on) begin
      perr_d = 1'b0;
      unique case (state_q)
        ENTRY: begin
          tick_d = term ? '0 : tick_q + TW'(1);
          if (bus.mid_pulse) begin
            dig_d = '0;
            if (clean) begin
              state_d = MODE;
              mode_d  = '0;
              bal_d   = topped;
            end else begin
              neg_d = 1'b0;
            end
          end else if (term) begin
            for (int i = 0; i < DIGITS; i++) begin
              if (bus.inc[i]) begin
                dig_d[i] = (dig_q[i] == 4'd9) ?
                           4'd0 : dig_q[i] + 4'd1;
              end
            end
            neg_d = neg_q ^ bus.sign;
          end
        end
        MODE: begin
          tick_d = '0;
          if (bus.mid_pulse) begin
            if (bal_q >= price) begin
              state_d = READY;
              req_d   = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end else if (bus.right_pulse) begin
            mode_d = (mode_q == MODE_LAST) ?
                     4'd0 : mode_q + 4'd1;
          end
        end
        READY: begin
          tick_d = '0;
          if (bus.start_ack) begin
            bal_d   = bal_q - price;
            req_d   = 1'b0;
            state_d = ENTRY;
          end
        end
        default: state_d = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTRY;
      tick_q  <= '0;
      dig_q   <= '0;
      neg_q   <= 1'b0;
      mode_q  <= '0;
      bal_q   <= '0;
      req_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      mode_q  <= mode_d;
      bal_q   <= bal_d;
      req_q   <= req_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    bus.st_light = 3'b001;
    unique case (state_q)
      ENTRY:   bus.st_light = 3'b001;
      MODE:    bus.st_light = 3'b011;
      READY:   bus.st_light = 3'b111;
      default: bus.st_light = 3'b001;
    endcase
  end

  assign bus.digits    = dig_q;
  assign bus.neg       = neg_q;
  assign bus.mode      = mode_q;
  assign bus.bal       = bal_q;
  assign bus.start_req = req_q;
  assign bus.price_err = perr_q;

endmodule

// File: tb/tb_pre_entry_n.sv
// Directed bench for pre_entry_n with a short tick period.
// Inputs change 1 time unit after each rising edge.
module tb_pre_entry_n;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  pre_entry_n_if #(.DIGITS(3), .BAL_W(14)) bus ();

  pre_entry_n #(
    .DIGITS(3),
    .TICK(4),
    .MODES(4),
    .PRICE_STEP(5),
    .BAL_W(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_mid();
    bus.mid_pulse = 1'b1;
    step(1);
    bus.mid_pulse = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.start_ack = 1'b1;
    step(1);
    bus.start_ack = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b0;
    bus.on = 1'b1;
    bus.inc = '0;
    bus.sign = 1'b0;
    bus.mid_pulse = 1'b0;
    bus.right_pulse = 1'b0;
    bus.start_ack = 1'b0;
    step(2);
    chk("rst_light", 32'(bus.st_light), 32'h1);
    chk("rst_bal", 32'(bus.bal), 0);
    chk("rst_digits", 32'(bus.digits), 0);
    chk("rst_req", 32'(bus.start_req), 0);
    rst = 1'b1;

    // two ticks of units+tens
    bus.inc = 3'b011;
    step(4);
    chk("tick1", 32'(bus.digits), 32'h011);
    step(4);
    bus.inc = 3'b000;
    chk("tick2", 32'(bus.digits), 32'h022);
    pulse_mid();
    chk("s1_light", 32'(bus.st_light), 32'h3);
    chk("s1_bal", 32'(bus.bal), 22);
    chk("s1_digits", 32'(bus.digits), 0);
    chk("s1_mode", 32'(bus.mode), 0);

    bus.right_pulse = 1'b1;
    step(3);
    bus.right_pulse = 1'b0;
    chk("s2_mode3", 32'(bus.mode), 3);
    pulse_mid();
    chk("s2_req", 32'(bus.start_req), 1);
    chk("s2_light", 32'(bus.st_light), 32'h7);
    bus.mid_pulse = 1'b1;
    bus.right_pulse = 1'b1;
    step(1);
    bus.mid_pulse = 1'b0;
    bus.right_pulse = 1'b0;
    chk("s2_ready_ign", 32'(bus.mode), 3);
    pulse_ack();
    chk("s2_bal", 32'(bus.bal), 2);
    chk("s2_ack_light", 32'(bus.st_light), 32'h1);
    chk("s2_ack_req", 32'(bus.start_req), 0);

    // enter 005, price error, wrap mode
    bus.inc = 3'b001;
    step(20);
    bus.inc = 3'b000;
    chk("s3_digits", 32'(bus.digits), 32'h005);
    pulse_mid();
    chk("s3_bal", 32'(bus.bal), 7);
    bus.right_pulse = 1'b1;
    step(2);
    bus.right_pulse = 1'b0;
    chk("s3_mode2", 32'(bus.mode), 2);
    pulse_mid();
    chk("s3_perr", 32'(bus.price_err), 1);
    chk("s3_perr_light", 32'(bus.st_light), 32'h3);
    step(1);
    chk("s3_perr_clr", 32'(bus.price_err), 0);
    bus.right_pulse = 1'b1;
    step(2);
    bus.right_pulse = 1'b0;
    chk("s3_wrap", 32'(bus.mode), 0);
    pulse_mid();
    chk("s3_ready", 32'(bus.st_light), 32'h7);
    pulse_ack();
    chk("s3_bal2", 32'(bus.bal), 2);

    // sign toggle and rejected confirms
    bus.sign = 1'b1;
    step(4);
    bus.sign = 1'b0;
    chk("s4_neg", 32'(bus.neg), 1);
    pulse_mid();
    chk("s4_neg_clr", 32'(bus.neg), 0);
    chk("s4_light", 32'(bus.st_light), 32'h1);
    chk("s4_bal", 32'(bus.bal), 2);
    bus.inc = 3'b001;
    pulse_mid();
    bus.inc = 3'b000;
    chk("s4_inc_light", 32'(bus.st_light), 32'h1);
    chk("s4_inc_bal", 32'(bus.bal), 2);

    // fresh start for saturation
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    bus.inc = 3'b110;
    step(36);
    bus.inc = 3'b001;
    step(20);
    bus.inc = 3'b000;
    chk("s5_995", 32'(bus.digits), 32'h995);
    pulse_mid();
    chk("s5_bal995", 32'(bus.bal), 995);
    pulse_mid();
    pulse_ack();
    chk("s5_bal990", 32'(bus.bal), 990);
    bus.inc = 3'b111;
    step(36);
    bus.inc = 3'b000;
    chk("s5_999", 32'(bus.digits), 32'h999);
    pulse_mid();
    chk("s5_sat", 32'(bus.bal), 999);
    pulse_mid();
    pulse_ack();
    chk("s5_bal994", 32'(bus.bal), 994);

    // confirm on the terminal tick drops the increment
    bus.inc = 3'b001;
    step(3);
    chk("s6_pre", 32'(bus.digits), 0);
    pulse_mid();
    chk("s6_coinc", 32'(bus.digits), 0);
    chk("s6_light", 32'(bus.st_light), 32'h1);
    step(4);
    chk("s6_wrap", 32'(bus.digits), 32'h001);

    // freeze with switch held and a lost confirm
    bus.on = 1'b0;
    step(5);
    pulse_mid();
    step(14);
    chk("fz_digits", 32'(bus.digits), 32'h001);
    chk("fz_bal", 32'(bus.bal), 994);
    chk("fz_light", 32'(bus.st_light), 32'h1);
    bus.inc = 3'b000;
    bus.on = 1'b1;
    step(1);
    chk("fz_resume", 32'(bus.digits), 32'h001);
    pulse_mid();
    chk("fz_bal995", 32'(bus.bal), 995);
    pulse_mid();
    chk("fz_ready", 32'(bus.start_req), 1);

    // asynchronous reset inside READY
    #2;
    rst = 1'b0;
    #1;
    chk("ar_light", 32'(bus.st_light), 32'h1);
    chk("ar_bal", 32'(bus.bal), 0);
    chk("ar_req", 32'(bus.start_req), 0);
    chk("ar_digits", 32'(bus.digits), 0);
    chk("ar_mode", 32'(bus.mode), 0);
    chk("ar_neg", 32'(bus.neg), 0);
    chk("ar_perr", 32'(bus.price_err), 0);
    step(1);
    rst = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
